// File: rtl/dram_axi_gate.sv
// dram_axi_gate: admits SoC AXI traffic into a DRAM controller only while it is
// calibrated, quiesces it for controller resets, and rebases addresses into the
// controller's window.
// Optional feature: define DRAM_GATE_PERF_EN to enable the AR/AW burst counters.

package dram_axi_gate_pkg;
  localparam int unsigned AxiAddrWidth = 64;
  localparam int unsigned AxiDataWidth = 64;
  localparam int unsigned AxiIdWidth   = 4;
  localparam int unsigned AxiUserWidth = 2;

  typedef struct packed {
    logic [AxiIdWidth-1:0]   id;
    logic [AxiAddrWidth-1:0] addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
    logic [AxiUserWidth-1:0] user;
  } axi_ax_t;

  typedef struct packed {
    logic [AxiDataWidth-1:0]   data;
    logic [AxiDataWidth/8-1:0] strb;
    logic                      last;
    logic [AxiUserWidth-1:0]   user;
  } axi_w_t;

  typedef struct packed {
    logic [AxiIdWidth-1:0]   id;
    logic [1:0]              resp;
    logic [AxiUserWidth-1:0] user;
  } axi_b_t;

  typedef struct packed {
    logic [AxiIdWidth-1:0]   id;
    logic [AxiDataWidth-1:0] data;
    logic [1:0]              resp;
    logic                    last;
    logic [AxiUserWidth-1:0] user;
  } axi_r_t;

  typedef struct packed {
    axi_ax_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    axi_ax_t ar;
    logic    ar_valid;
    logic    r_ready;
  } axi_req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   ar_ready;
    logic   w_ready;
    axi_b_t b;
    logic   b_valid;
    axi_r_t r;
    logic   r_valid;
  } axi_resp_t;
endpackage

// The struct type parameters default to concrete package types (rather than
// plain logic) so the block elaborates on its own; the field accesses below
// need a real AXI struct.
module dram_axi_gate #(
  parameter int unsigned AddrWidth     = 64,
  parameter int unsigned DramAddrWidth = 30,
  parameter logic [63:0] DramBase      = 64'h8000_0000,
  parameter int unsigned MaxReadTxns   = 8,
  parameter int unsigned MaxWriteTxns  = 8,
  parameter type         axi_req_t     = dram_axi_gate_pkg::axi_req_t,
  parameter type         axi_resp_t    = dram_axi_gate_pkg::axi_resp_t
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        calib_done_i,
  input  logic        flush_req_i,
  output logic        flush_ack_o,
  output logic        calib_lost_o,
  input  axi_req_t    slv_req_i,
  output axi_resp_t   slv_rsp_o,
  output axi_req_t    mst_req_o,
  input  axi_resp_t   mst_rsp_i,
  output logic [31:0] rd_bursts_o,
  output logic [31:0] wr_bursts_o
);

  // Outstanding-burst counters only need to reach 255.
  localparam int unsigned CntWidth = 8;

  typedef enum logic [1:0] {
    WAIT_CALIB = 2'd0,
    ACTIVE     = 2'd1,
    DRAIN      = 2'd2,
    FLUSHED    = 2'd3
  } state_e;

  state_e               state;
  logic [CntWidth-1:0]  rd_cnt;
  logic [CntWidth-1:0]  wr_cnt;
  logic                 aw_open;
  logic                 ar_open;
  logic                 aw_hs;
  logic                 ar_hs;
  logic                 b_hs;
  logic                 r_last_hs;
  logic [AddrWidth-1:0] aw_off;
  logic [AddrWidth-1:0] ar_off;

  // New bursts are admitted only while calibrated and below the outstanding limit.
  always_comb begin
    aw_open = rst_ni && (state == ACTIVE) && (wr_cnt < CntWidth'(MaxWriteTxns));
    ar_open = rst_ni && (state == ACTIVE) && (rd_cnt < CntWidth'(MaxReadTxns));
    aw_off  = slv_req_i.aw.addr - AddrWidth'(DramBase);
    ar_off  = slv_req_i.ar.addr - AddrWidth'(DramBase);
  end

  // Zero-latency forwarding; only address channels are gated and rebased.
  always_comb begin
    mst_req_o          = slv_req_i;
    mst_req_o.aw.addr  = AddrWidth'(aw_off[DramAddrWidth-1:0]);
    mst_req_o.ar.addr  = AddrWidth'(ar_off[DramAddrWidth-1:0]);
    mst_req_o.aw_valid = slv_req_i.aw_valid & aw_open;
    mst_req_o.ar_valid = slv_req_i.ar_valid & ar_open;
    mst_req_o.w_valid  = slv_req_i.w_valid & rst_ni;

    slv_rsp_o          = mst_rsp_i;
    slv_rsp_o.aw_ready = mst_rsp_i.aw_ready & aw_open;
    slv_rsp_o.ar_ready = mst_rsp_i.ar_ready & ar_open;
    slv_rsp_o.w_ready  = mst_rsp_i.w_ready & rst_ni;
    slv_rsp_o.b.user   = '0;
    slv_rsp_o.r.user   = '0;
  end

  // Handshakes that open and close bursts on the controller side.
  always_comb begin
    aw_hs     = mst_req_o.aw_valid & mst_rsp_i.aw_ready;
    ar_hs     = mst_req_o.ar_valid & mst_rsp_i.ar_ready;
    b_hs      = mst_rsp_i.b_valid & slv_req_i.b_ready;
    r_last_hs = mst_rsp_i.r_valid & slv_req_i.r_ready & mst_rsp_i.r.last;
  end

  // Gate state machine; flush_ack_o is high exactly while in FLUSHED.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= WAIT_CALIB;
      flush_ack_o  <= 1'b0;
      calib_lost_o <= 1'b0;
    end else begin
      case (state)
        WAIT_CALIB: begin
          if (calib_done_i && !flush_req_i) state <= ACTIVE;
        end
        ACTIVE: begin
          if (flush_req_i || !calib_done_i) begin
            state <= DRAIN;
            if (!calib_done_i) calib_lost_o <= 1'b1;
          end
        end
        DRAIN: begin
          if ((rd_cnt == '0) && (wr_cnt == '0)) begin
            if (flush_req_i) begin
              state       <= FLUSHED;
              flush_ack_o <= 1'b1;
            end else begin
              state <= WAIT_CALIB;
            end
          end
        end
        FLUSHED: begin
          if (!flush_req_i) begin
            state       <= WAIT_CALIB;
            flush_ack_o <= 1'b0;
          end
        end
        default: begin
          state       <= WAIT_CALIB;
          flush_ack_o <= 1'b0;
        end
      endcase
    end
  end

  // Outstanding burst tracking; open and close on the same edge cancel.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      case ({aw_hs, b_hs})
        2'b10:   wr_cnt <= wr_cnt + CntWidth'(1);
        2'b01:   wr_cnt <= wr_cnt - CntWidth'(1);
        default: wr_cnt <= wr_cnt;
      endcase
      case ({ar_hs, r_last_hs})
        2'b10:   rd_cnt <= rd_cnt + CntWidth'(1);
        2'b01:   rd_cnt <= rd_cnt - CntWidth'(1);
        default: rd_cnt <= rd_cnt;
      endcase
    end
  end

`ifdef DRAM_GATE_PERF_EN
  // Saturating burst counters for performance monitoring.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_bursts_o <= '0;
      wr_bursts_o <= '0;
    end else begin
      if (ar_hs && (rd_bursts_o != 32'hFFFF_FFFF)) rd_bursts_o <= rd_bursts_o + 32'd1;
      if (aw_hs && (wr_bursts_o != 32'hFFFF_FFFF)) wr_bursts_o <= wr_bursts_o + 32'd1;
    end
  end
`else
  assign rd_bursts_o = '0;
  assign wr_bursts_o = '0;
`endif

`ifndef SYNTHESIS
  logic r_hs;
  assign r_hs = mst_rsp_i.r_valid & slv_req_i.r_ready;

  // Responses must only arrive for bursts this gate let through.
  b_without_write: assert property (@(posedge clk_i) disable iff (!rst_ni)
    b_hs |-> (wr_cnt != '0)) else $error("B handshake with no write outstanding");
  r_without_read: assert property (@(posedge clk_i) disable iff (!rst_ni)
    r_hs |-> (rd_cnt != '0)) else $error("R handshake with no read outstanding");
  wr_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (b_hs && !aw_hs) |-> (wr_cnt != '0)) else $error("write counter underflow");
  rd_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (r_last_hs && !ar_hs) |-> (rd_cnt != '0)) else $error("read counter underflow");
`endif

endmodule

// File: tb/tb_dram_axi_gate.sv
// Testbench for dram_axi_gate: table vectors, directed corner sequences and
// randomized traffic checked every cycle against a behavioural model.
module tb_dram_axi_gate;
  import dram_axi_gate_pkg::*;

  localparam int unsigned MaxRd    = 2;
  localparam int unsigned MaxWr    = 3;
  localparam logic [63:0] Base     = 64'h8000_0000;
  localparam logic [63:0] DramMask = 64'h3FFF_FFFF;
  localparam int ModeWait    = 0;
  localparam int ModeActive  = 1;
  localparam int ModeDrain   = 2;
  localparam int ModeFlushed = 3;
`ifdef DRAM_GATE_PERF_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        calib = 1'b0;
  logic        flush = 1'b0;
  logic        flush_ack;
  logic        calib_lost;
  axi_req_t    sreq;
  axi_resp_t   srsp;
  axi_req_t    mreq;
  axi_resp_t   mrsp;
  logic [31:0] rd_b;
  logic [31:0] wr_b;

  int checks = 0;
  int failures = 0;

  // Behavioural model of the gate.
  int          m_mode;
  int          m_rd;
  int          m_wr;
  bit          m_lost;
  longint      m_rdb;
  longint      m_wrb;

  always #5 clk = ~clk;

  dram_axi_gate #(
    .AddrWidth    (64),
    .DramAddrWidth(30),
    .DramBase     (64'h8000_0000),
    .MaxReadTxns  (MaxRd),
    .MaxWriteTxns (MaxWr),
    .axi_req_t    (axi_req_t),
    .axi_resp_t   (axi_resp_t)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .calib_done_i(calib),
    .flush_req_i (flush),
    .flush_ack_o (flush_ack),
    .calib_lost_o(calib_lost),
    .slv_req_i   (sreq),
    .slv_rsp_o   (srsp),
    .mst_req_o   (mreq),
    .mst_rsp_i   (mrsp),
    .rd_bursts_o (rd_b),
    .wr_bursts_o (wr_b)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_mode = ModeWait;
    m_rd   = 0;
    m_wr   = 0;
    m_lost = 1'b0;
    m_rdb  = 0;
    m_wrb  = 0;
  endtask

  task automatic idle();
    sreq = '0;
    mrsp = '0;
    sreq.b_ready = 1'b1;
    sreq.r_ready = 1'b1;
  endtask

  // Check all outputs against the model, then advance one clock.
  task automatic tick();
    bit aw_ok, ar_ok, aw_hs, ar_hs, b_hs, rl_hs;
    int nmode;
    #2;
    aw_ok = (m_mode == ModeActive) && (m_wr < int'(MaxWr));
    ar_ok = (m_mode == ModeActive) && (m_rd < int'(MaxRd));
    chk("mst_aw_valid", 64'(mreq.aw_valid), 64'(sreq.aw_valid & aw_ok));
    chk("slv_aw_ready", 64'(srsp.aw_ready), 64'(mrsp.aw_ready & aw_ok));
    chk("mst_ar_valid", 64'(mreq.ar_valid), 64'(sreq.ar_valid & ar_ok));
    chk("slv_ar_ready", 64'(srsp.ar_ready), 64'(mrsp.ar_ready & ar_ok));
    chk("mst_awaddr", mreq.aw.addr, (sreq.aw.addr - Base) & DramMask);
    chk("mst_araddr", mreq.ar.addr, (sreq.ar.addr - Base) & DramMask);
    chk("mst_aw_fields", 64'({mreq.aw.id, mreq.aw.len, mreq.aw.size, mreq.aw.burst, mreq.aw.user}),
        64'({sreq.aw.id, sreq.aw.len, sreq.aw.size, sreq.aw.burst, sreq.aw.user}));
    chk("mst_ar_fields", 64'({mreq.ar.id, mreq.ar.len, mreq.ar.size, mreq.ar.burst, mreq.ar.user}),
        64'({sreq.ar.id, sreq.ar.len, sreq.ar.size, sreq.ar.burst, sreq.ar.user}));
    chk("w_pass", 64'({mreq.w_valid, srsp.w_ready, mreq.w.last, mreq.w.strb}),
        64'({sreq.w_valid, mrsp.w_ready, sreq.w.last, sreq.w.strb}));
    chk("w_data", mreq.w.data, sreq.w.data);
    chk("b_pass", 64'({srsp.b_valid, mreq.b_ready, srsp.b.id, srsp.b.resp, srsp.b.user}),
        64'({mrsp.b_valid, sreq.b_ready, mrsp.b.id, mrsp.b.resp, 2'b00}));
    chk("r_pass", 64'({srsp.r_valid, mreq.r_ready, srsp.r.last, srsp.r.id, srsp.r.resp, srsp.r.user}),
        64'({mrsp.r_valid, sreq.r_ready, mrsp.r.last, mrsp.r.id, mrsp.r.resp, 2'b00}));
    chk("r_data", srsp.r.data, mrsp.r.data);
    chk("flush_ack", 64'(flush_ack), 64'(m_mode == ModeFlushed));
    chk("calib_lost", 64'(calib_lost), 64'(m_lost));
    chk("rd_cnt", 64'(dut.rd_cnt), 64'(m_rd));
    chk("wr_cnt", 64'(dut.wr_cnt), 64'(m_wr));
    chk("rd_bursts", 64'(rd_b), 64'(m_rdb));
    chk("wr_bursts", 64'(wr_b), 64'(m_wrb));

    aw_hs = sreq.aw_valid && mrsp.aw_ready && aw_ok;
    ar_hs = sreq.ar_valid && mrsp.ar_ready && ar_ok;
    b_hs  = mrsp.b_valid && sreq.b_ready;
    rl_hs = mrsp.r_valid && sreq.r_ready && mrsp.r.last;
    nmode = m_mode;
    case (m_mode)
      ModeWait:    if (calib && !flush) nmode = ModeActive;
      ModeActive:  if (flush || !calib) begin
                     nmode = ModeDrain;
                     if (!calib) m_lost = 1'b1;
                   end
      ModeDrain:   if (m_rd == 0 && m_wr == 0) nmode = flush ? ModeFlushed : ModeWait;
      default:     if (!flush) nmode = ModeWait;
    endcase
    m_wr = m_wr + int'(aw_hs) - int'(b_hs);
    m_rd = m_rd + int'(ar_hs) - int'(rl_hs);
    if (PerfEn && ar_hs && m_rdb < 64'hFFFF_FFFF) m_rdb++;
    if (PerfEn && aw_hs && m_wrb < 64'hFFFF_FFFF) m_wrb++;
    @(posedge clk);
    #1;
    m_mode = nmode;
  endtask

  typedef struct {
    logic        calib;
    logic [63:0] addr;
    logic        exp_ready;
    logic [63:0] exp_addr;
  } vec_t;

  vec_t vecs[15];

  initial begin
    for (int i = 0; i < 10; i++) vecs[i] = '{1'b0, 64'h8000_1000, 1'b0, 64'h1000};
    vecs[10] = '{1'b1, 64'h8000_1000, 1'b0, 64'h1000};
    vecs[11] = '{1'b1, 64'h8000_1000, 1'b1, 64'h1000};
    vecs[12] = '{1'b1, 64'hBFFF_FFC0, 1'b1, 64'h3FFF_FFC0};
    vecs[13] = '{1'b1, 64'hC000_0040, 1'b0, 64'h40};
    vecs[14] = '{1'b1, 64'h7FFF_FFF0, 1'b0, 64'h3FFF_FFF0};

    // Reset state.
    idle();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_flush_ack", 64'(flush_ack), 64'd0);
    chk("reset_calib_lost", 64'(calib_lost), 64'd0);
    chk("reset_bursts", 64'({rd_b, wr_b}), 64'd0);
    rst_n = 1'b1;

    // AR held from cycle 0; calibration arrives at cycle 10; then limit and rebasing.
    for (int i = 0; i < 15; i++) begin
      idle();
      calib = vecs[i].calib;
      sreq.ar_valid = 1'b1;
      sreq.ar.addr  = vecs[i].addr;
      mrsp.ar_ready = 1'b1;
      #1;
      chk("vec_ar_ready", 64'(srsp.ar_ready), 64'(vecs[i].exp_ready));
      chk("vec_araddr", mreq.ar.addr, vecs[i].exp_addr);
      tick();
    end

    // Third AR waits for the first R last, then goes the following cycle.
    idle();
    sreq.ar_valid = 1'b1;
    sreq.ar.addr  = 64'h8000_2000;
    mrsp.ar_ready = 1'b1;
    tick();
    mrsp.r_valid = 1'b1;
    mrsp.r.data  = 64'hDEAD_BEEF_0000_0001;
    tick();
    mrsp.r.last = 1'b1;
    #1;
    chk("ar_blocked_on_r_last", 64'(srsp.ar_ready), 64'd0);
    tick();
    mrsp.r_valid = 1'b0;
    #1;
    chk("ar_accepted_after_r_last", 64'(srsp.ar_ready), 64'd1);
    tick();
    idle();
    mrsp.r_valid = 1'b1;
    mrsp.r.last  = 1'b1;
    repeat (2) tick();

    // Two writes outstanding, then a flush.
    idle();
    sreq.aw_valid = 1'b1;
    sreq.aw.addr  = 64'h8000_4000;
    mrsp.aw_ready = 1'b1;
    repeat (2) tick();
    sreq.aw_valid = 1'b0;
    flush = 1'b1;
    tick();
    sreq.aw_valid = 1'b1;
    sreq.w_valid  = 1'b1;
    mrsp.w_ready  = 1'b1;
    sreq.w.data   = 64'h0123_4567_89AB_CDEF;
    #1;
    chk("aw_blocked_in_drain", 64'(mreq.aw_valid), 64'd0);
    chk("w_open_in_drain", 64'(srsp.w_ready), 64'd1);
    tick();
    sreq.w_valid = 1'b0;
    mrsp.b_valid = 1'b1;
    mrsp.b.id    = 4'h5;
    repeat (2) tick();
    mrsp.b_valid = 1'b0;
    chk("no_ack_at_last_b", 64'(flush_ack), 64'd0);
    tick();
    chk("flush_ack_after_last_b", 64'(flush_ack), 64'd1);
    tick();
    flush = 1'b0;
    mrsp.aw_ready = 1'b0;
    tick();
    chk("ack_drops_with_flush", 64'(flush_ack), 64'd0);
    chk("aw_blocked_wait_calib", 64'(mreq.aw_valid), 64'd0);
    tick();
    chk("aw_reopened", 64'(mreq.aw_valid), 64'd1);

    // Calibration loss with one read outstanding.
    idle();
    sreq.ar_valid = 1'b1;
    sreq.ar.addr  = 64'h8000_0100;
    mrsp.ar_ready = 1'b1;
    tick();
    idle();
    calib = 1'b0;
    tick();
    chk("calib_lost_set", 64'(calib_lost), 64'd1);
    mrsp.r_valid = 1'b1;
    mrsp.r.last  = 1'b1;
    tick();
    idle();
    tick();
    chk("lost_back_to_wait_no_ack", 64'(flush_ack), 64'd0);
    calib = 1'b1;
    sreq.ar_valid = 1'b1;
    mrsp.ar_ready = 1'b0;
    #1;
    chk("ar_closed_in_wait", 64'(mreq.ar_valid), 64'd0);
    tick();
    chk("ar_open_after_recal", 64'(mreq.ar_valid), 64'd1);

    // Simultaneous AW and B with one write outstanding.
    idle();
    sreq.aw_valid = 1'b1;
    mrsp.aw_ready = 1'b1;
    tick();
    mrsp.b_valid = 1'b1;
    tick();
    chk("wr_cnt_aw_and_b", 64'(dut.wr_cnt), 64'd1);
    idle();
    mrsp.b_valid = 1'b1;
    tick();

    // Reset with a read in flight, all handshake inputs high.
    idle();
    sreq.ar_valid = 1'b1;
    mrsp.ar_ready = 1'b1;
    tick();
    sreq = '1;
    mrsp = '1;
    rst_n = 1'b0;
    #1;
    chk("rst_slv_readies", 64'({srsp.aw_ready, srsp.ar_ready, srsp.w_ready}), 64'd0);
    chk("rst_mst_valids", 64'({mreq.aw_valid, mreq.ar_valid, mreq.w_valid}), 64'd0);
    chk("rst_rd_cnt", 64'(dut.rd_cnt), 64'd0);
    chk("rst_flags", 64'({flush_ack, calib_lost}), 64'd0);
    chk("rst_bursts", 64'({rd_b, wr_b}), 64'd0);
    @(posedge clk);
    #1;
    idle();
    model_reset();
    rst_n = 1'b1;
    tick();

    // Five reads and three writes for the burst counters.
    for (int k = 0; k < 5; k++) begin
      idle();
      sreq.ar_valid = 1'b1;
      sreq.ar.addr  = 64'h8000_0000 + 64'(k * 64);
      mrsp.ar_ready = 1'b1;
      tick();
      idle();
      mrsp.r_valid = 1'b1;
      mrsp.r.last  = 1'b1;
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      idle();
      sreq.aw_valid = 1'b1;
      mrsp.aw_ready = 1'b1;
      tick();
      idle();
      mrsp.b_valid = 1'b1;
      tick();
    end
    idle();
    chk("rd_bursts_five", 64'(rd_b), PerfEn ? 64'd5 : 64'd0);
    chk("wr_bursts_three", 64'(wr_b), PerfEn ? 64'd3 : 64'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 24) == 0) flush = ~flush;
      calib = ($urandom_range(0, 39) != 0);
      sreq.aw_valid = 1'($urandom);
      sreq.ar_valid = 1'($urandom);
      sreq.aw.addr  = {$urandom, $urandom};
      sreq.ar.addr  = {$urandom, $urandom};
      sreq.aw.id    = 4'($urandom);
      sreq.ar.len   = 8'($urandom);
      sreq.w_valid  = 1'($urandom);
      sreq.w.data   = {$urandom, $urandom};
      sreq.b_ready  = 1'($urandom);
      sreq.r_ready  = 1'($urandom);
      mrsp.aw_ready = 1'($urandom);
      mrsp.ar_ready = 1'($urandom);
      mrsp.w_ready  = 1'($urandom);
      mrsp.b_valid  = (m_wr > 0) && ($urandom_range(0, 2) == 0);
      mrsp.b.id     = 4'($urandom);
      mrsp.b.user   = 2'($urandom);
      mrsp.r_valid  = (m_rd > 0) && ($urandom_range(0, 1) == 0);
      mrsp.r.last   = 1'($urandom);
      mrsp.r.data   = {$urandom, $urandom};
      mrsp.r.user   = 2'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
